// File: rtl/riscv.sv
// Shared RISC-V privileged-architecture types used by the PMP region encoder.
package riscv;

  // pmpcfg.A field encoding: address-matching mode of a PMP entry.
  typedef enum logic [1:0] {
    OFF   = 2'b00,
    TOR   = 2'b01,
    NA4   = 2'b10,
    NAPOT = 2'b11
  } pmp_addr_mode_t;

endpackage

// File: rtl/pmp_region_encoder_if.sv
// Request/response handshake bundle between a region-programming client
// (master) and the PMP region encoder (slave).
interface pmp_region_encoder_if #(
  parameter  int PLEN       = 56,
  parameter  int NR_ENTRIES = 16,
  localparam int IW         = $clog2(NR_ENTRIES)
);

  // Request channel
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [IW-1:0]         req_idx_i;
  riscv::pmp_addr_mode_t req_mode_i;
  logic [PLEN-1:0]       req_base_i;
  logic [PLEN-1:0]       req_top_i;
  logic [7:0]            req_log2size_i;
  logic [2:0]            req_perm_i;      // {X, W, R}
  logic                  req_lock_i;

  // Response channel
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [1:0]            rsp_code_o;

  modport master (
    output req_valid_i, req_idx_i, req_mode_i, req_base_i, req_top_i,
           req_log2size_i, req_perm_i, req_lock_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_code_o
  );

  modport slave (
    input  req_valid_i, req_idx_i, req_mode_i, req_base_i, req_top_i,
           req_log2size_i, req_perm_i, req_lock_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_code_o
  );

endinterface

// File: rtl/pmp_region_encoder.sv
// PMP region encoder: accepts a region description (mode, bounds, perms),
// validates it against the lock state and encoding rules, then emits the
// pmpaddr write(s) followed by the pmpcfg byte write, and finally a response.
// All strobes are Moore outputs decoded from the state register: a strobe is
// high for exactly the one cycle its state lasts and is consumed by the CSR
// file at the closing rising edge of that cycle.
module pmp_region_encoder #(
  parameter  int PLEN       = 56,
  parameter  int PMP_LEN    = 54,
  parameter  int NR_ENTRIES = 16,
  localparam int IW         = $clog2(NR_ENTRIES)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pmp_region_encoder_if.slave   bus_if,
  input  logic [NR_ENTRIES-1:0] locked_i,
  output logic                  pmpaddr_we_o,
  output logic [IW-1:0]         pmpaddr_idx_o,
  output logic [PMP_LEN-1:0]    pmpaddr_o,
  output logic                  pmpcfg_we_o,
  output logic [IW-1:0]         pmpcfg_idx_o,
  output logic [7:0]            pmpcfg_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CHECK   = 3'd1;
  localparam logic [2:0] WR_PREV = 3'd2;
  localparam logic [2:0] WR_ADDR = 3'd3;
  localparam logic [2:0] WR_CFG  = 3'd4;
  localparam logic [2:0] RESP    = 3'd5;

  localparam logic [1:0] CODE_OK      = 2'd0;
  localparam logic [1:0] CODE_ALIGN   = 2'd1;
  localparam logic [1:0] CODE_ILLEGAL = 2'd2;
  localparam logic [1:0] CODE_LOCKED  = 2'd3;

  // Largest legal NAPOT region is half the physical address space.
  localparam logic [7:0] MAX_LOG2 = 8'(PLEN - 1);

  logic [2:0]            state_q, state_d;
  logic                  accept;

  logic [IW-1:0]         idx_q;
  riscv::pmp_addr_mode_t mode_q;
  logic [PLEN-1:0]       base_q;
  logic [PLEN-1:0]       top_q;
  logic [7:0]            log2size_q;
  logic [2:0]            perm_q;
  logic                  lock_q;
  logic [1:0]            code_q, code_d;

  logic                  lock_err, illegal_err, align_err;
  logic [PLEN-1:0]       align_mask;
  logic [PLEN-1:0]       napot_ones;

  assign accept = bus_if.req_valid_i && (state_q == IDLE);

  // Low log2size bits that must be zero in a naturally aligned base.
  assign align_mask = ~({PLEN{1'b1}} << log2size_q);
  // NAPOT trailing-ones pattern in pmpaddr units: 2^(log2size-3) - 1.
  assign napot_ones = ~({PLEN{1'b1}} << (log2size_q - 8'd3));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering; blocking here would race.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Capture the request on the handshake and latch the check result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q      <= '0;
      mode_q     <= riscv::OFF;
      base_q     <= '0;
      top_q      <= '0;
      log2size_q <= '0;
      perm_q     <= '0;
      lock_q     <= 1'b0;
      code_q     <= CODE_OK;
    end else begin
      if (accept) begin
        idx_q      <= bus_if.req_idx_i;
        mode_q     <= bus_if.req_mode_i;
        base_q     <= bus_if.req_base_i;
        top_q      <= bus_if.req_top_i;
        log2size_q <= bus_if.req_log2size_i;
        perm_q     <= bus_if.req_perm_i;
        lock_q     <= bus_if.req_lock_i;
      end
      if (state_q == CHECK) code_q <= code_d;
    end
  end

  // Validate the captured request; LOCKED > ILLEGAL > ALIGN > OK.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    lock_err    = locked_i[idx_q];
    illegal_err = perm_q[1] && !perm_q[0];   // W without R is reserved
    align_err   = 1'b0;
    case (mode_q)
      riscv::TOR: begin
        // TOR also reuses the previous entry's pmpaddr as its lower bound.
        if ((idx_q != '0) && locked_i[idx_q - IW'(1)]) lock_err = 1'b1;
        if (base_q >= top_q) illegal_err = 1'b1;
        // Entry 0's lower bound is hard-wired to zero.
        if ((idx_q == '0) && (base_q != '0)) illegal_err = 1'b1;
        align_err = (base_q[1:0] != 2'b00) || (top_q[1:0] != 2'b00);
      end
      riscv::NA4: begin
        if (log2size_q != 8'd2) illegal_err = 1'b1;
        align_err = (base_q & align_mask) != '0;
      end
      riscv::NAPOT: begin
        if ((log2size_q < 8'd3) || (log2size_q > MAX_LOG2)) illegal_err = 1'b1;
        align_err = (base_q & align_mask) != '0;
      end
      default: ;
    endcase

    if      (lock_err)    code_d = CODE_LOCKED;
    else if (illegal_err) code_d = CODE_ILLEGAL;
    else if (align_err)   code_d = CODE_ALIGN;
    else                  code_d = CODE_OK;
  end

  // Next-state logic: the cfg write is always last so the region is only
  // enabled once its address registers hold the new bounds.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CHECK;
      CHECK: begin
        if (code_d != CODE_OK)                             state_d = RESP;
        else if ((mode_q == riscv::TOR) && (idx_q != '0))  state_d = WR_PREV;
        else if (mode_q == riscv::OFF)                     state_d = WR_CFG;
        else                                               state_d = WR_ADDR;
      end
      WR_PREV: state_d = WR_ADDR;
      WR_ADDR: state_d = WR_CFG;
      WR_CFG:  state_d = RESP;
      RESP:    if (bus_if.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decode write strobes and their payloads; idx/data are zero when idle.
  always_comb begin
    pmpaddr_we_o  = 1'b0;
    pmpaddr_idx_o = '0;
    pmpaddr_o     = '0;
    pmpcfg_we_o   = 1'b0;
    pmpcfg_idx_o  = '0;
    pmpcfg_o      = '0;
    case (state_q)
      WR_PREV: begin
        pmpaddr_we_o  = 1'b1;
        pmpaddr_idx_o = idx_q - IW'(1);
        pmpaddr_o     = PMP_LEN'(base_q >> 2);
      end
      WR_ADDR: begin
        pmpaddr_we_o  = 1'b1;
        pmpaddr_idx_o = idx_q;
        case (mode_q)
          riscv::NA4:   pmpaddr_o = PMP_LEN'(base_q >> 2);
          riscv::NAPOT: pmpaddr_o = PMP_LEN'((base_q >> 2) | napot_ones);
          riscv::TOR:   pmpaddr_o = PMP_LEN'(top_q >> 2);
          default:      pmpaddr_o = '0;
        endcase
      end
      WR_CFG: begin
        pmpcfg_we_o  = 1'b1;
        pmpcfg_idx_o = idx_q;
        pmpcfg_o     = {lock_q, 2'b00, mode_q, perm_q};
      end
      default: ;
    endcase
  end

  assign bus_if.req_ready_o = (state_q == IDLE);
  assign bus_if.rsp_valid_o = (state_q == RESP);
  assign bus_if.rsp_code_o  = (state_q == RESP) ? code_q : CODE_OK;

endmodule

// File: tb/tb_pmp_region_encoder.sv
// Directed, table-driven bench for pmp_region_encoder. Each vector lists the
// request plus the cycle offset (k, counted in falling edges after the accept
// edge, k=0 being the CHECK cycle) at which each strobe and the response must
// appear; hand sequences cover backpressure and mid-operation reset.
module tb_pmp_region_encoder;
  import riscv::*;

  typedef struct {
    pmp_addr_mode_t mode;
    logic [3:0]     idx;
    logic [55:0]    base;
    logic [55:0]    top;
    logic [7:0]     l2;
    logic [2:0]     perm;
    logic           lock;
    logic [15:0]    locked;
    logic [1:0]     code;
    int             prev_k;
    logic [53:0]    prev_data;
    int             addr_k;
    logic [53:0]    addr_data;
    int             cfg_k;
    logic [7:0]     cfg_data;
    int             rsp_k;
  } vec_t;

  logic        clk;
  logic        rst_i;
  logic [15:0] locked;
  logic        pmpaddr_we;
  logic [3:0]  pmpaddr_idx;
  logic [53:0] pmpaddr;
  logic        pmpcfg_we;
  logic [3:0]  pmpcfg_idx;
  logic [7:0]  pmpcfg;

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs[$];

  pmp_region_encoder_if #(.PLEN(56), .NR_ENTRIES(16)) bus_if ();

  pmp_region_encoder #(.PLEN(56), .PMP_LEN(54), .NR_ENTRIES(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .bus_if        (bus_if.slave),
    .locked_i      (locked),
    .pmpaddr_we_o  (pmpaddr_we),
    .pmpaddr_idx_o (pmpaddr_idx),
    .pmpaddr_o     (pmpaddr),
    .pmpcfg_we_o   (pmpcfg_we),
    .pmpcfg_idx_o  (pmpcfg_idx),
    .pmpcfg_o      (pmpcfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(pmp_addr_mode_t mode, logic [3:0] idx, logic [55:0] base,
                              logic [55:0] top, logic [7:0] l2, logic [2:0] perm, logic lock,
                              logic [15:0] lk, logic [1:0] code, int prev_k, logic [53:0] prev_data,
                              int addr_k, logic [53:0] addr_data, int cfg_k, logic [7:0] cfg_data,
                              int rsp_k);
    vec_t v;
    v.mode = mode; v.idx = idx; v.base = base; v.top = top; v.l2 = l2; v.perm = perm;
    v.lock = lock; v.locked = lk; v.code = code; v.prev_k = prev_k; v.prev_data = prev_data;
    v.addr_k = addr_k; v.addr_data = addr_data; v.cfg_k = cfg_k; v.cfg_data = cfg_data;
    v.rsp_k = rsp_k;
    return v;
  endfunction

  // Error vector: no strobes, response one cycle after CHECK.
  function automatic vec_t mk_err(pmp_addr_mode_t mode, logic [3:0] idx, logic [55:0] base,
                                  logic [55:0] top, logic [7:0] l2, logic [2:0] perm,
                                  logic [15:0] lk, logic [1:0] code);
    return mk(mode, idx, base, top, l2, perm, 1'b0, lk, code, -1, '0, -1, '0, -1, '0, 1);
  endfunction

  task automatic drive_req(input vec_t v);
    locked                = v.locked;
    bus_if.req_idx_i      = v.idx;
    bus_if.req_mode_i     = v.mode;
    bus_if.req_base_i     = v.base;
    bus_if.req_top_i      = v.top;
    bus_if.req_log2size_i = v.l2;
    bus_if.req_perm_i     = v.perm;
    bus_if.req_lock_i     = v.lock;
    bus_if.req_valid_i    = 1'b1;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    logic [3:0]  pidx;
    logic [63:0] ea, ec, er;
    pidx = v.idx - 4'd1;
    check($sformatf("v%0d ready_before", n), 64'(bus_if.req_ready_o), 64'd1);
    drive_req(v);
    @(posedge clk);
    @(negedge clk);
    bus_if.req_valid_i = 1'b0;
    for (int k = 0; k <= v.rsp_k; k++) begin
      if (k > 0) @(negedge clk);
      if (k == v.prev_k)      ea = 64'({1'b1, pidx, v.prev_data});
      else if (k == v.addr_k) ea = 64'({1'b1, v.idx, v.addr_data});
      else                    ea = '0;
      ec = (k == v.cfg_k) ? 64'({1'b1, v.idx, v.cfg_data}) : 64'd0;
      er = (k == v.rsp_k) ? 64'({1'b0, 1'b1, v.code}) : 64'd0;
      check($sformatf("v%0d k%0d addr", n, k), 64'({pmpaddr_we, pmpaddr_idx, pmpaddr}), ea);
      check($sformatf("v%0d k%0d cfg", n, k), 64'({pmpcfg_we, pmpcfg_idx, pmpcfg}), ec);
      check($sformatf("v%0d k%0d rsp", n, k),
            64'({bus_if.req_ready_o, bus_if.rsp_valid_o, bus_if.rsp_code_o}), er);
    end
    @(negedge clk);
    check($sformatf("v%0d idle_after", n),
          64'({bus_if.req_ready_o, bus_if.rsp_valid_o, pmpaddr_we, pmpcfg_we}), 64'(4'b1000));
    locked = '0;
  endtask

  initial begin
    vec_t v;

    // Reference NAPOT, TOR and error cases, then the remaining rule corners.
    vecs.push_back(mk(NAPOT, 4'd3, 56'h8000_0000, 56'h0, 8'd12, 3'b111, 1'b0, 16'h0, 2'd0,
                      -1, 54'h0, 1, 54'h2000_01FF, 2, 8'h1F, 3));
    vecs.push_back(mk(TOR, 4'd5, 56'h1000, 56'h2000, 8'd0, 3'b001, 1'b0, 16'h0, 2'd0,
                      1, 54'h400, 2, 54'h800, 3, 8'h09, 4));
    vecs.push_back(mk_err(NAPOT, 4'd2, 56'h8000_0800, 56'h0, 8'd12, 3'b111, 16'h0, 2'd1));
    vecs.push_back(mk_err(NAPOT, 4'd3, 56'h8000_0800, 56'h0, 8'd12, 3'b111, 16'h0008, 2'd3));
    vecs.push_back(mk_err(NA4, 4'd1, 56'h100, 56'h0, 8'd3, 3'b001, 16'h0, 2'd2));
    vecs.push_back(mk_err(NAPOT, 4'd2, 56'h8000_0000, 56'h0, 8'd12, 3'b010, 16'h0, 2'd2));
    vecs.push_back(mk(NA4, 4'd7, 56'h1234_5678, 56'h0, 8'd2, 3'b101, 1'b1, 16'h0, 2'd0,
                      -1, 54'h0, 1, 54'h048D_159E, 2, 8'h95, 3));
    vecs.push_back(mk(OFF, 4'd9, 56'h0, 56'h0, 8'd0, 3'b011, 1'b1, 16'h0, 2'd0,
                      -1, 54'h0, -1, 54'h0, 1, 8'h83, 2));
    vecs.push_back(mk(TOR, 4'd0, 56'h0, 56'h4000, 8'd0, 3'b011, 1'b0, 16'h0, 2'd0,
                      -1, 54'h0, 1, 54'h1000, 2, 8'h0B, 3));
    vecs.push_back(mk_err(TOR, 4'd0, 56'h100, 56'h4000, 8'd0, 3'b011, 16'h0, 2'd2));
    vecs.push_back(mk_err(TOR, 4'd2, 56'h2000, 56'h1000, 8'd0, 3'b001, 16'h0, 2'd2));
    vecs.push_back(mk_err(TOR, 4'd6, 56'h1000, 56'h2000, 8'd0, 3'b001, 16'h0020, 2'd3));
    vecs.push_back(mk_err(TOR, 4'd2, 56'h1001, 56'h2000, 8'd0, 3'b001, 16'h0, 2'd1));
    vecs.push_back(mk_err(NAPOT, 4'd1, 56'h1000, 56'h0, 8'd2, 3'b001, 16'h0, 2'd2));
    vecs.push_back(mk_err(NAPOT, 4'd1, 56'h0, 56'h0, 8'd56, 3'b001, 16'h0, 2'd2));
    vecs.push_back(mk(NAPOT, 4'd1, 56'h0, 56'h0, 8'd55, 3'b001, 1'b0, 16'h0, 2'd0,
                      -1, 54'h0, 1, 54'h000F_FFFF_FFFF_FFFF, 2, 8'h19, 3));
    vecs.push_back(mk_err(NA4, 4'd4, 56'h1002, 56'h0, 8'd2, 3'b001, 16'h0, 2'd1));
    vecs.push_back(mk_err(TOR, 4'd3, 56'h1000, 56'h2003, 8'd0, 3'b001, 16'h0, 2'd1));
    vecs.push_back(mk_err(NA4, 4'd4, 56'h1000, 56'h0, 8'd2, 3'b001, 16'h0010, 2'd3));
    vecs.push_back(mk_err(OFF, 4'd0, 56'h0, 56'h0, 8'd0, 3'b110, 16'h0, 2'd2));
    vecs.push_back(mk(TOR, 4'd5, 56'h1000, 56'h2000, 8'd0, 3'b001, 1'b0, 16'h0008, 2'd0,
                      1, 54'h400, 2, 54'h800, 3, 8'h09, 4));

    // Reset state.
    rst_i = 1'b1;
    locked = '0;
    bus_if.req_valid_i = 1'b0;
    bus_if.req_idx_i = '0;
    bus_if.req_mode_i = OFF;
    bus_if.req_base_i = '0;
    bus_if.req_top_i = '0;
    bus_if.req_log2size_i = '0;
    bus_if.req_perm_i = '0;
    bus_if.req_lock_i = 1'b0;
    bus_if.rsp_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    check("reset_state",
          64'({bus_if.req_ready_o, bus_if.rsp_valid_o, bus_if.rsp_code_o, pmpaddr_we, pmpcfg_we}),
          64'(6'b100000));

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Response backpressure: valid and code held, no new request accepted.
    bus_if.rsp_ready_i = 1'b0;
    drive_req(vecs[2]);
    @(posedge clk);
    @(negedge clk);
    bus_if.req_valid_i = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp c%0d rsp", c),
            64'({bus_if.req_ready_o, bus_if.rsp_valid_o, bus_if.rsp_code_o}), 64'(4'b0101));
      @(negedge clk);
    end
    bus_if.rsp_ready_i = 1'b1;
    check("bp handshake_cycle",
          64'({bus_if.req_ready_o, bus_if.rsp_valid_o, bus_if.rsp_code_o}), 64'(4'b0101));
    @(negedge clk);
    check("bp idle_after",
          64'({bus_if.req_ready_o, bus_if.rsp_valid_o, bus_if.rsp_code_o}), 64'(4'b1000));

    // Reset during the pmpaddr write of a NAPOT request abandons it.
    v = vecs[0];
    drive_req(v);
    @(posedge clk);
    @(negedge clk);
    bus_if.req_valid_i = 1'b0;
    @(negedge clk);
    check("rst wr_addr_seen", 64'({pmpaddr_we, pmpaddr_idx, pmpaddr}),
          64'({1'b1, 4'd3, 54'h2000_01FF}));
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("rst ready_after",
          64'({bus_if.req_ready_o, bus_if.rsp_valid_o, pmpaddr_we, pmpcfg_we}), 64'(4'b1000));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("rst quiet c%0d", c),
            64'({bus_if.req_ready_o, bus_if.rsp_valid_o, pmpaddr_we, pmpcfg_we}), 64'(4'b1000));
    end

    // Encoder still works after the abandoned request.
    run_vec(100, vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pmp_region_encoder.md
PMP_REGION_ENCODER -- requirements
Module: pmp_region_encoder

Interface
REQ-001 SHALL have parameter PLEN, default 56, physical address width.
REQ-002 SHALL have parameter PMP_LEN, default 54, pmpaddr register width.
REQ-003 SHALL have parameter NR_ENTRIES, default 16, number of PMP entries; IW = $clog2(NR_ENTRIES).
REQ-004 SHALL have port clk_i, input, 1, single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports req_valid_i (input, 1) and req_ready_o (output, 1), request handshake.
REQ-007 SHALL have ports req_idx_i (input, IW) and req_mode_i (input, riscv::pmp_addr_mode_t), target entry and mode.
REQ-008 SHALL have ports req_base_i and req_top_i (input, PLEN each) and req_log2size_i (input, 8), region bounds; top is used only for TOR, log2size only for NA4/NAPOT.
REQ-009 SHALL have ports req_perm_i (input, 3, {X,W,R}) and req_lock_i (input, 1).
REQ-010 SHALL have port locked_i, input, NR_ENTRIES, current L bit of each entry.
REQ-011 SHALL have ports pmpaddr_we_o (output, 1), pmpaddr_idx_o (output, IW) and pmpaddr_o (output, PMP_LEN), pmpaddr write strobe.
REQ-012 SHALL have ports pmpcfg_we_o (output, 1), pmpcfg_idx_o (output, IW) and pmpcfg_o (output, 8), pmpcfg byte write strobe.
REQ-013 SHALL have ports rsp_valid_o (output, 1), rsp_ready_i (input, 1) and rsp_code_o (output, 2), response handshake.

Function
REQ-014 SHALL implement states IDLE, CHECK, WR_PREV, WR_ADDR, WR_CFG and RESP.
REQ-015 SHALL drive req_ready_o=1 only in IDLE, and SHALL capture the request on valid&&ready, moving to CHECK.
REQ-016 SHALL, in CHECK, compute the error code with priority LOCKED(3) > ILLEGAL(2) > ALIGN(1) > OK(0).
REQ-017 SHALL flag LOCKED when locked_i[idx]=1, or for TOR with idx>0 when locked_i[idx-1]=1.
REQ-018 SHALL flag ILLEGAL when perm has W=1 and R=0; NA4 with log2size!=2; NAPOT with log2size<3 or log2size>PLEN-1; TOR with base>=top; or TOR with idx=0 and base!=0.
REQ-019 SHALL flag ALIGN when NA4/NAPOT base is not aligned to 2^log2size, or when TOR base[1:0] or top[1:0] is nonzero.
REQ-020 SHALL go from CHECK to RESP on error (no writes); otherwise to WR_PREV (TOR, idx>0), WR_ADDR (NA4/NAPOT/TOR idx=0) or WR_CFG (OFF).
REQ-021 SHALL, in WR_PREV, pulse pmpaddr_we_o for one cycle with idx-1 and data base>>2, then move to WR_ADDR.
REQ-022 SHALL, in WR_ADDR, pulse pmpaddr_we_o for one cycle with idx and data: NA4 base>>2; NAPOT (base>>2)|(2^(log2size-3)-1); TOR top>>2; truncated to PMP_LEN.
REQ-023 SHALL, in WR_CFG, pulse pmpcfg_we_o for one cycle with data {L, 2'b00, A[1:0], X, W, R}, where A is the mode encoding (OFF=0, TOR=1, NA4=2, NAPOT=3).
REQ-024 SHALL write pmpcfg last, so a region is never enabled before its address registers are written.
REQ-025 SHALL issue at most one write strobe per cycle; pmpaddr_we_o and pmpcfg_we_o SHALL never be high together.
REQ-026 SHALL, in RESP, hold rsp_valid_o=1 with a stable rsp_code_o until rsp_ready_i=1, then return to IDLE in the same cycle the handshake completes.
REQ-027 SHALL hold idx/data outputs at 0 whenever their strobe is low.
REQ-028 Latency from accept edge T SHALL be: NAPOT/NA4 addr write T+2, cfg write T+3, rsp_valid T+4; TOR idx>0 one cycle later; error rsp_valid T+2; OFF cfg T+2, rsp_valid T+3.

Reset
REQ-029 SHALL, on rst_i=1 at a clock edge, enter IDLE with all strobes, rsp_valid_o and rsp_code_o at 0 and req_ready_o=1 from the next cycle.
REQ-030 SHALL, on reset mid-operation, abandon the request: no further strobes for it, and no response.

Verification
REQ-031 NAPOT, idx=3, base 0x8000_0000, log2size=12, perm=3'b111, L=0 -> T+2: pmpaddr[3]=0x2000_01FF; T+3: pmpcfg[3]=0x1F; T+4: rsp code 0.
REQ-032 TOR, idx=5, base 0x1000, top 0x2000, perm=3'b001 -> pmpaddr[4]=0x400, then pmpaddr[5]=0x800, then pmpcfg[5]=0x09, then rsp code 0.
REQ-033 NAPOT, base 0x8000_0800, log2size=12 -> rsp code 1 at T+2, no strobes.
REQ-034 locked_i[3]=1 with NAPOT idx=3 and also misaligned -> code 3; NA4 with log2size=3 -> code 2; perm=3'b010 -> code 2.
REQ-035 rsp_ready_i held low 5 cycles -> rsp_valid_o and rsp_code_o stable, req_ready_o=0 throughout; IDLE after the handshake.
REQ-036 rst_i asserted during the WR_ADDR cycle of a NAPOT request -> no pmpcfg strobe, no response, req_ready_o=1 the cycle after reset.
